// File: rtl/imem_program_loader.sv
// imem_program_loader: turns a framed byte stream (16-bit word count, little-endian
// payload words, 8-bit additive checksum) into instruction-memory writes, and holds
// the core in reset until a complete image with a valid checksum has been loaded.
module imem_program_loader #(
    parameter int unsigned          DEPTH     = 256,
    parameter int unsigned          ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    logic [15:0] cnt;      // image length in words
    logic [15:0] widx;     // index of the word being assembled; 16 bits covers any count
    logic [1:0]  bidx;     // byte position inside the current word
    logic [31:0] shift;    // partially assembled word
    logic [7:0]  sum;      // running payload checksum

    logic        xfer;
    logic [15:0] hdr_cnt;
    logic        last_word;

    assign xfer      = rx_valid & rx_ready;
    assign hdr_cnt   = {rx_data, cnt[7:0]};
    assign last_word = (widx == cnt - 16'd1);

    // Stream is accepted while a load is in progress; DONE/ERR wait for reload.
    assign rx_ready  = (state != S_DONE) && (state != S_ERR);

    // Load sequencer: header parse, word packing, write strobe, checksum verdict.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_HDR0;
            cnt        <= '0;
            widx       <= '0;
            bidx       <= '0;
            shift      <= '0;
            sum        <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
            core_reset <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we    <= 1'b0;
            // Core is released one cycle after DONE is reached, not on the same edge.
            core_reset <= (state != S_DONE);
            case (state)
                S_HDR0: begin
                    if (xfer) begin
                        cnt[7:0] <= rx_data;
                        state    <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (xfer) begin
                        cnt[15:8] <= rx_data;
                        if ({16'd0, hdr_cnt} > DEPTH) begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end else if (hdr_cnt == 16'd0) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        sum                <= sum + rx_data;
                        shift[8*bidx +: 8] <= rx_data;
                        bidx               <= bidx + 2'd1;
                        if (bidx == 2'd3) begin
                            // Word complete: strobe it out on the next cycle, no stall.
                            imem_we    <= 1'b1;
                            imem_wdata <= {rx_data, shift[23:0]};
                            imem_addr  <= BASE_ADDR + ADDR_W'({widx, 2'b00});
                            widx       <= widx + 16'd1;
                            if (last_word) begin
                                state <= S_CSUM;
                            end
                        end
                    end
                end
                S_CSUM: begin
                    if (xfer) begin
                        if (rx_data == sum) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    if (reload) begin
                        state      <= S_HDR0;
                        cnt        <= '0;
                        widx       <= '0;
                        bidx       <= '0;
                        sum        <= '0;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        core_reset <= 1'b1;
                    end
                end
                default: begin
                    state <= S_HDR0;
                end
            endcase
        end
    end

endmodule
